// File: rtl/imem_pkg.sv
// Shared types and default geometry for the instruction-memory fetch controller.
package imem_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int DEF_SIZE   = 32;
  localparam int DEF_LENGTH = 256;

endpackage

// File: rtl/imem_loader.sv
// Boot-image write side: load counter, ready/strobe generation and the done pulse
// raised on the final word of the image (load_last or the top memory location).
module imem_loader
  import imem_pkg::*;
#(
  parameter  int LENGTH = DEF_LENGTH,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic          load_valid,
  input  logic          load_last,
  output logic          load_ready,
  output logic          we,
  output logic          done,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] cnt;
  logic          at_top;

  assign at_top     = (cnt == AW'(LENGTH - 1));
  assign load_ready = active;
  assign we         = load_valid & load_ready;
  assign done       = we & (load_last | at_top);
  assign addr       = cnt;

  // Restart from zero after the last word so a non-power-of-two LENGTH never overruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (we) cnt <= done ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: boot-load the image, then fetch one word per handshake.
// Optional build macro FETCH_TRAP_EN: halt with trap on fetch past the last location.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter  int SIZE   = DEF_SIZE,
  parameter  int LENGTH = DEF_LENGTH,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] load_data,
  input  logic            load_last,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata,
  output logic [SIZE-1:0] instr,
  output logic [AW-1:0]   instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_pc,
  input  logic            halt_req,
  output logic            halted,
  output logic            trap
);

  fetch_state_t    state, state_nxt;
  logic [AW-1:0]   pc, pc_nxt;
  logic [SIZE-1:0] instr_nxt;
  logic [AW-1:0]   instr_pc_nxt;
  logic            valid_nxt;
  logic            advance;
  logic            pc_last;
  logic [AW-1:0]   load_addr;
  logic            load_done;

  imem_loader #(.LENGTH(LENGTH)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (state == LOAD),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .we         (mem_we),
    .done       (load_done),
    .addr       (load_addr)
  );

  assign mem_addr  = (state == LOAD) ? load_addr : pc;
  assign mem_wdata = load_data;
  assign halted    = (state == HALT);
  assign advance   = !instr_valid | instr_ready;
  assign pc_last   = (pc == AW'(LENGTH - 1));

`ifdef FETCH_TRAP_EN
  logic trap_q, trap_nxt;
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    valid_nxt    = instr_valid;
`ifdef FETCH_TRAP_EN
    trap_nxt     = trap_q;
`endif
    case (state)
      LOAD: begin
        if (load_done) state_nxt = RUN;
      end
      RUN: begin
        // Priority: halt, then (trap drain), then redirect, then normal advance.
        if (halt_req) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
        end
`ifdef FETCH_TRAP_EN
        else if (trap_q) begin
          // The overrun word is already latched; stop once decode has taken it.
          if (advance) begin
            state_nxt = HALT;
            valid_nxt = 1'b0;
          end
        end
`endif
        else if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
        end else if (advance) begin
          instr_nxt    = mem_rdata;
          instr_pc_nxt = pc;
          valid_nxt    = 1'b1;
`ifdef FETCH_TRAP_EN
          if (pc_last) trap_nxt = 1'b1;
          else         pc_nxt   = pc + 1'b1;
`else
          pc_nxt = pc_last ? '0 : pc + 1'b1;
`endif
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= valid_nxt;
    end
  end

`ifdef FETCH_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_nxt;
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural instruction memory.
module tb_imem_fetch_ctrl;
  localparam int SIZE   = 32;
  localparam int LENGTH = 256;
  localparam int AW     = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_valid, load_ready, load_last;
  logic [SIZE-1:0] load_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [SIZE-1:0] mem_wdata, mem_rdata;
  logic [SIZE-1:0] instr;
  logic [AW-1:0]   instr_pc;
  logic            instr_valid, instr_ready;
  logic            redirect_valid;
  logic [AW-1:0]   redirect_pc;
  logic            halt_req, halted, trap;

  int tests = 0;
  int fails = 0;

  logic [SIZE-1:0] mem [LENGTH];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.SIZE(SIZE), .LENGTH(LENGTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_data      (load_data),
    .load_last      (load_last),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .trap           (trap)
  );

  // Background pattern lets fetches from unloaded locations be predicted.
  initial begin
    for (int i = 0; i < LENGTH; i++) mem[i] = 32'hA000_0000 | i;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 0; load_last = 0; load_data = '0;
    instr_ready = 0; redirect_valid = 0; redirect_pc = '0; halt_req = 0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_trap", trap, 0);
    chk("rst_mem_we", mem_we, 0);

    // Three-word image, last flagged on the third.
    load_valid = 1; load_data = 32'h2008_0005; #1;
    chk("ld0_we", mem_we, 1); chk("ld0_addr", mem_addr, 0);
    step(); load_data = 32'h2009_0003; #1;
    chk("ld1_we", mem_we, 1); chk("ld1_addr", mem_addr, 1);
    step(); load_data = 32'h0109_5020; load_last = 1; #1;
    chk("ld2_we", mem_we, 1); chk("ld2_addr", mem_addr, 2);
    step(); load_valid = 0; load_last = 0; #1;
    chk("run_load_ready", load_ready, 0);
    chk("run_first_valid0", instr_valid, 0);
    step();
    chk("first_valid", instr_valid, 1);
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_pc", instr_pc, 0);

    // Stall three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", instr, 32'h2008_0005);
      chk("stall_pc", instr_pc, 0);
      chk("stall_valid", instr_valid, 1);
    end
    instr_ready = 1;
    step();
    chk("adv_pc1", instr_pc, 1);
    chk("adv_instr1", instr, 32'h2009_0003);
    instr_ready = 0;
    step();
    chk("hold_pc1", instr_pc, 1);

    // Redirect while stalled on pc 1.
    redirect_valid = 1; redirect_pc = 8'h40;
    step(); redirect_valid = 0;
    chk("redir_bubble", instr_valid, 0);
    step();
    chk("redir_valid", instr_valid, 1);
    chk("redir_pc", instr_pc, 8'h40);
    chk("redir_instr", instr, 32'hA000_0040);
    instr_ready = 1;
    step(); chk("seq_pc41", instr_pc, 8'h41);
    step(); chk("seq_pc42", instr_pc, 8'h42);
    chk("seq_instr42", instr, 32'hA000_0042);

    // Halt with a simultaneous redirect: halt wins.
    halt_req = 1; redirect_valid = 1; redirect_pc = 8'h10;
    step(); halt_req = 0; redirect_valid = 0;
    chk("halt_halted", halted, 1);
    chk("halt_valid", instr_valid, 0);
    chk("halt_pc_kept", mem_addr, 8'h43);
    load_valid = 1; #1;
    chk("halt_load_ready", load_ready, 0);
    chk("halt_mem_we", mem_we, 0);
    step();
    chk("halt_sticky", halted, 1);
    load_valid = 0;

    // Async reset mid-run, then full 256-word load without load_last.
    rst_n = 0; #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_pc", instr_pc, 0);
    chk("rst2_load_ready", load_ready, 1);
    step(); rst_n = 1; instr_ready = 0;
    for (int i = 0; i < LENGTH; i++) begin
      load_valid = 1; load_data = 32'hB000_0000 | i; #1;
      chk("full_addr", mem_addr, i);
      chk("full_we", mem_we, 1);
      step();
    end
    chk("full_ready_drop", load_ready, 0);
    chk("full_we_off", mem_we, 0);
    chk("full_valid0", instr_valid, 0);
    load_valid = 0; instr_ready = 1;
    step();
    chk("full_first_instr", instr, 32'hB000_0000);
    chk("full_first_pc", instr_pc, 0);

    // Redirect to the top location and run past it.
    redirect_valid = 1; redirect_pc = 8'hFF;
    step(); redirect_valid = 0;
    chk("top_bubble", instr_valid, 0);
    step();
    chk("top_pc", instr_pc, 8'hFF);
    chk("top_instr", instr, 32'hB000_00FF);
`ifdef FETCH_TRAP_EN
    chk("top_trap", trap, 1);
    step();
    chk("trap_halted", halted, 1);
    chk("trap_valid", instr_valid, 0);
    chk("trap_pc_kept", mem_addr, 8'hFF);
`else
    chk("top_trap_off", trap, 0);
    step();
    chk("wrap_pc", instr_pc, 0);
    chk("wrap_instr", instr, 32'hB000_0000);
    halt_req = 1; redirect_valid = 1; redirect_pc = 8'h10;
    step(); halt_req = 0; redirect_valid = 0;
    chk("wrap_halted", halted, 1);
    chk("wrap_valid", instr_valid, 0);
    chk("wrap_redir_ignored", mem_addr, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
